// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter.
// State encoding is fixed so that other units can decode busy/idle consistently.
package reg_write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// The request vector is duplicated so the wrap-around becomes a plain priority search.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any_req
);

   logic [2*NUM_REQ-1:0] dbl_req;
   logic [2*NUM_REQ-1:0] dbl_mask;
   logic [2*NUM_REQ-1:0] dbl_masked;
   logic                 found;

   // Masking below ptr in the lower copy leaves the upper copy to supply the wrapped candidates.
   always_comb begin
      dbl_req    = {req, req};
      dbl_mask   = {(2*NUM_REQ){1'b1}} << ptr;
      dbl_masked = dbl_req & dbl_mask;
      found      = 1'b0;
      win_idx    = '0;
      for (int j = 0; j < 2*NUM_REQ; j++) begin
         if (!found && dbl_masked[j]) begin
            found   = 1'b1;
            win_idx = (j >= NUM_REQ) ? IDX_W'(j - NUM_REQ) : IDX_W'(j);
         end
      end
   end

   assign any_req = |req;
   assign winner  = any_req ? (NUM_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated register among NUM_REQ writers.
// Each accepted request takes IDLE -> WRITE -> DONE, so at most one write per three cycles.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic                      reg_en_o,
   output logic [DATA_W-1:0]         reg_d_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      busy_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         state_q;
   arb_state_t         state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   win_idx;
   logic [DATA_W-1:0]  data_q;
   logic [NUM_REQ-1:0] win_onehot;
   logic [NUM_REQ-1:0] done_q;
   logic               any_req;
   logic               accept;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (req_i),
      .ptr     (ptr_q),
      .winner  (win_onehot),
      .win_idx (win_idx),
      .any_req (any_req)
   );

   // Arbitration only happens in IDLE; requests seen while busy simply wait there.
   always_comb begin
      state_d = state_q;
      gnt_o   = '0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               gnt_o   = win_onehot;
               accept  = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Data is captured on the grant edge so the requester may change it afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         data_q  <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= '0;
         if (accept) begin
            data_q  <= data_i[win_idx*DATA_W +: DATA_W];
            owner_q <= win_idx;
            ptr_q   <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
         end
         if (state_q == ST_WRITE) begin
            done_q <= NUM_REQ'(1) << owner_q;
         end
      end
   end

   assign reg_en_o = (state_q == ST_WRITE);
   assign reg_d_o  = reg_en_o ? data_q : '0;
   assign done_o   = done_q;
   assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: cycle model plus a write scoreboard,
// with the shared enable-gated register modelled next to the arbiter.
module tb_reg_write_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [NUM_REQ-1:0]        req_i = '0;
   logic [NUM_REQ*DATA_W-1:0] data_i = '0;
   logic [NUM_REQ-1:0]        gnt_o;
   logic                      reg_en_o;
   logic [DATA_W-1:0]         reg_d_o;
   logic [NUM_REQ-1:0]        done_o;
   logic                      busy_o;
   logic [DATA_W-1:0]         shared_reg = '0;

   typedef struct packed {
      logic [1:0] owner;
      logic [7:0] data;
   } wr_t;

   wr_t        sb_q[$];
   int         grant_log[$];
   logic [7:0] write_log[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         m_state = 0;
   int         m_ptr = 0;
   int         m_owner = 0;
   logic [7:0] m_data = '0;
   logic [7:0] m_reg = '0;
   int         pend_owner = 0;
   logic       pend_valid = 1'b0;

   reg_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req_i),
      .data_i   (data_i),
      .gnt_o    (gnt_o),
      .reg_en_o (reg_en_o),
      .reg_d_o  (reg_d_o),
      .done_o   (done_o),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (reg_en_o) shared_reg <= reg_d_o;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int modelWinner(input logic [NUM_REQ-1:0] req);
      int w;
      w = -1;
      if (m_state == 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (req[idx]) begin
               w = idx;
               break;
            end
         end
      end
      return w;
   endfunction

   // One clock cycle: drive, check against the model at posedge+1, then advance the model.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ*DATA_W-1:0] data);
      int         w;
      logic [3:0] eg;
      logic [7:0] slice;
      wr_t        e;
      req_i  = req;
      data_i = data;
      #1;
      w  = modelWinner(req);
      eg = (w >= 0) ? 4'(1 << w) : 4'h0;
      slice = (w >= 0) ? data[w*DATA_W +: DATA_W] : 8'h00;
      checkOutput("gnt", 32'(gnt_o), 32'(eg));
      checkOutput("reg_en", 32'(reg_en_o), 32'(m_state == 1));
      checkOutput("reg_d", 32'(reg_d_o), (m_state == 1) ? 32'(m_data) : 32'h0);
      checkOutput("done", 32'(done_o), (m_state == 2) ? 32'(1 << m_owner) : 32'h0);
      checkOutput("busy", 32'(busy_o), 32'(m_state != 0));
      checkOutput("reg_q", 32'(shared_reg), 32'(m_reg));
      if (w >= 0) begin
         e.owner = 2'(w);
         e.data  = slice;
         sb_q.push_back(e);
         grant_log.push_back(w);
      end
      if (reg_en_o) begin
         checkOutput("sb_pending", 32'(sb_q.size() != 0), 32'h1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("sb_data", 32'(reg_d_o), 32'(e.data));
            pend_owner = int'(e.owner);
            pend_valid = 1'b1;
         end
         write_log.push_back(reg_d_o);
      end
      if (done_o != '0) begin
         checkOutput("sb_done", 32'(done_o), pend_valid ? 32'(1 << pend_owner) : 32'h0);
         pend_valid = 1'b0;
      end
      @(posedge clk);
      case (m_state)
         0: if (w >= 0) begin
               m_owner = w;
               m_data  = slice;
               m_ptr   = (w + 1) % NUM_REQ;
               m_state = 1;
            end
         1: begin
               m_reg   = m_data;
               m_state = 2;
            end
         default: m_state = 0;
      endcase
      #1;
   endtask

   // Reset is raised between edges so its asynchronous effect is observed before any clock.
   task automatic applyReset();
      reset = 1'b1;
      req_i = '0;
      #1;
      checkOutput("rst_gnt", 32'(gnt_o), 32'h0);
      checkOutput("rst_en", 32'(reg_en_o), 32'h0);
      checkOutput("rst_d", 32'(reg_d_o), 32'h0);
      checkOutput("rst_done", 32'(done_o), 32'h0);
      checkOutput("rst_busy", 32'(busy_o), 32'h0);
      m_state = 0;
      m_ptr   = 0;
      m_owner = 0;
      m_data  = '0;
      sb_q.delete();
      pend_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         exp_order[5];
      logic [7:0] exp_writes[5];
      logic [31:0] d_all;
      exp_order  = '{0, 1, 2, 3, 0};
      exp_writes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      d_all      = {8'h13, 8'h12, 8'h11, 8'h10};

      #2;
      applyReset();

      // Single request from requester 2, then ptr=3 shown by a full request set.
      applyStimulus(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      checkOutput("t1_reg", 32'(shared_reg), 32'hA5);
      applyStimulus(4'b1111, d_all);
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);

      // All four requesting continuously from a fresh pointer.
      applyReset();
      grant_log.delete();
      write_log.delete();
      for (int i = 0; i < 15; i++) applyStimulus(4'b1111, d_all);
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      checkOutput("t2_ngrants", 32'(grant_log.size()), 32'd5);
      checkOutput("t2_nwrites", 32'(write_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < grant_log.size()) checkOutput("t2_order", 32'(grant_log[i]), 32'(exp_order[i]));
         if (i < write_log.size()) checkOutput("t2_write", 32'(write_log[i]), 32'(exp_writes[i]));
      end

      // Data changed after grant must not affect the write.
      applyStimulus(4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00});
      applyStimulus(4'b0000, {8'h00, 8'h00, 8'hFF, 8'h00});
      applyStimulus(4'b0000, {8'h00, 8'h00, 8'hFF, 8'h00});
      applyStimulus(4'b0000, '0);
      checkOutput("t3_reg", 32'(shared_reg), 32'h3C);

      // Request raised while busy waits for IDLE.
      applyStimulus(4'b0001, {8'h77, 8'h00, 8'h00, 8'h5A});
      applyStimulus(4'b1000, {8'h77, 8'h00, 8'h00, 8'h00});
      applyStimulus(4'b1000, {8'h77, 8'h00, 8'h00, 8'h00});
      applyStimulus(4'b1000, {8'h77, 8'h00, 8'h00, 8'h00});
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      checkOutput("t4_reg", 32'(shared_reg), 32'h77);

      // Reset during WRITE aborts the write and returns ptr to 0.
      applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hE1});
      applyReset();
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      checkOutput("t5_reg", 32'(shared_reg), 32'h77);
      applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      applyStimulus(4'b0000, '0);
      checkOutput("t5_reg2", 32'(shared_reg), 32'h11);

      // Request pulsed while busy and withdrawn is never served.
      applyStimulus(4'b0001, {8'h00, 8'h99, 8'h00, 8'h66});
      applyStimulus(4'b0100, {8'h00, 8'h99, 8'h00, 8'h00});
      applyStimulus(4'b0000, '0);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, '0);
      checkOutput("t6_reg", 32'(shared_reg), 32'h66);

      checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
